// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, framing-error detect, break hold-off.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } state_t;

  logic [1:0]    sync_reg;
  logic          rx_s;
  state_t        state_reg,  state_next;
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic [2:0]    idx_reg,    idx_next;
  logic [7:0]    data_reg,   data_next;
  logic [7:0]    byte_reg,   byte_next;
  logic          dv_reg,     dv_next;
  logic          ferr_reg,   ferr_next;
  logic          active_reg, active_next;
  logic          hold_reg,   hold_next;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_reg, par_bit_next;
  logic          perr_reg,    perr_next;
`endif

  assign rx_s = sync_reg[1];

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      sync_reg    <= 2'b11;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      data_reg    <= '0;
      byte_reg    <= '0;
      dv_reg      <= 1'b0;
      ferr_reg    <= 1'b0;
      active_reg  <= 1'b0;
      hold_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      sync_reg    <= {sync_reg[0], i_RX_Serial};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      data_reg    <= data_next;
      byte_reg    <= byte_next;
      dv_reg      <= dv_next;
      ferr_reg    <= ferr_next;
      active_reg  <= active_next;
      hold_reg    <= hold_next;
`ifdef UART_RX_PARITY_EN
      par_bit_reg <= par_bit_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    data_next    = data_reg;
    byte_next    = byte_reg;
    dv_next      = 1'b0;
    ferr_next    = 1'b0;
    active_next  = active_reg;
    hold_next    = hold_reg;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit_reg;
    perr_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        idx_next  = '0;
        hold_next = 1'b0;
        if (!rx_s) begin
          state_next  = START;
          active_next = 1'b1;
        end
      end
      START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
          end else begin
            // Start bit gone by mid-bit: treat as noise.
            state_next  = IDLE;
            active_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next          = '0;
          data_next[idx_reg] = rx_s;
          if (idx_reg == 3'd7) begin
            idx_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next     = '0;
          par_bit_next = rx_s;
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next    = '0;
          state_next  = CLEANUP;
          active_next = 1'b0;
          if (rx_s) begin
            byte_next = data_reg;
            dv_next   = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_next = par_bit_reg ^ (^data_reg);
`endif
          end else begin
            ferr_next = 1'b1;
            hold_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      CLEANUP: begin
        // After a framing error, wait for the line to return high (break hold-off).
        if (!hold_reg || rx_s) begin
          state_next = IDLE;
          hold_next  = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
    endcase
  end

  assign o_RX_DV     = dv_reg;
  assign o_RX_Byte   = byte_reg;
  assign o_RX_Active = active_reg;
  assign o_Frame_Err = ferr_reg;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_reg;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx at CLKS_PER_BIT=8; a frame-level model predicts
// every strobe (byte, parity flag, framing error) and its timing window relative to the start edge.
module tb_uart_rx;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS    = PAR_EN ? 11 : 10;
  localparam int STOP_MID = (NBITS - 1) * CPB + CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_active;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Rst       (rst),
    .i_RX_Serial (rx),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte),
    .o_RX_Active (rx_active),
    .o_Frame_Err (frame_err),
    .o_Parity_Err(parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  int         dv_cyc_q[$];
  logic [7:0] dv_byte_q[$];
  logic       dv_pe_q[$];
  int         ferr_q[$];
  int         perr_cnt = 0;
  int         act_cnt  = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_dv) begin
        dv_cyc_q.push_back(cyc);
        dv_byte_q.push_back(rx_byte);
        dv_pe_q.push_back(parity_err);
      end
      if (frame_err)  ferr_q.push_back(cyc);
      if (parity_err) perr_cnt++;
      if (rx_active)  act_cnt++;
    end
  end

  // Model expectations, one entry per frame sent
  int         exp_start_q[$];
  logic       exp_good_q[$];
  logic [7:0] exp_byte_q[$];
  logic       exp_pe_q[$];
  logic [7:0] last_good_byte = 8'h00;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    #1;
    dv_cyc_q.delete();
    dv_byte_q.delete();
    dv_pe_q.delete();
    ferr_q.delete();
    perr_cnt = 0;
    act_cnt  = 0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    exp_start_q.push_back(cyc);
    exp_good_q.push_back(stop);
    exp_byte_q.push_back(b);
    exp_pe_q.push_back(PAR_EN && stop && (par != ^b));
    if (stop) last_good_byte = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic check_batch(input string name);
    int n_good = 0;
    int n_bad  = 0;
    int n_pe   = 0;
    foreach (exp_good_q[i]) begin
      if (exp_good_q[i]) n_good++; else n_bad++;
      if (exp_pe_q[i]) n_pe++;
    end
    chk({name, "_dv_count"},   dv_cyc_q.size(), n_good);
    chk({name, "_ferr_count"}, ferr_q.size(),   n_bad);
    chk({name, "_perr_count"}, perr_cnt,        n_pe);
    while (exp_good_q.size() > 0) begin
      int         st;
      logic       good;
      logic [7:0] eb;
      logic       epe;
      int         rel;
      st   = exp_start_q.pop_front();
      good = exp_good_q.pop_front();
      eb   = exp_byte_q.pop_front();
      epe  = exp_pe_q.pop_front();
      if (good) begin
        if (dv_cyc_q.size() > 0) begin
          rel = dv_cyc_q.pop_front() - st;
          chk({name, "_byte"},   dv_byte_q.pop_front(), eb);
          chk({name, "_parity"}, dv_pe_q.pop_front(),   epe);
          chk({name, "_dv_time"}, (rel >= STOP_MID && rel <= STOP_MID + 5), 1);
        end
      end else if (ferr_q.size() > 0) begin
        rel = ferr_q.pop_front() - st;
        chk({name, "_ferr_time"}, (rel >= STOP_MID && rel <= STOP_MID + 5), 1);
      end
    end
    dv_cyc_q.delete();
    dv_byte_q.delete();
    dv_pe_q.delete();
    ferr_q.delete();
    perr_cnt = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       par;
    int         gap;
    int         spacing;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_dv",     rx_dv,      0);
    chk("reset_byte",   rx_byte,    8'h00);
    chk("reset_active", rx_active,  0);
    chk("reset_ferr",   frame_err,  0);
    chk("reset_perr",   parity_err, 0);
    rst = 1'b0;
    idle(4);

    // Single byte
    clear_mon();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(12);
    check_batch("single");
    chk("single_active_low", rx_active, 0);

    // Back-to-back with zero idle
    clear_mon();
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(12);
    spacing = (dv_cyc_q.size() >= 2) ? dv_cyc_q[1] - dv_cyc_q[0] : -1;
    chk("b2b_spacing", spacing, NBITS * CPB);
    check_batch("b2b");

    // Start glitch
    clear_mon();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(16);
    chk("glitch_dv_count",   dv_cyc_q.size(), 0);
    chk("glitch_ferr_count", ferr_q.size(),   0);
    chk("glitch_active_seen", act_cnt > 0,    1);
    chk("glitch_active_len",  act_cnt <= 6,   1);
    chk("glitch_active_low",  rx_active,      0);

    // Framing error followed by a long break
    clear_mon();
    b = last_good_byte;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    rx = 1'b0;
    #1 act_cnt = 0;
    repeat (20 * CPB) @(negedge clk);
    chk("break_active_quiet", act_cnt, 0);
    chk("break_byte_held", rx_byte, b);
    idle(2 * CPB);
    check_batch("ferr");
    clear_mon();
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(12);
    check_batch("after_break");

    // Reset during data bit 4
    clear_mon();
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (3) @(negedge clk);
    chk("pre_reset_active", rx_active, 1);
    rst = 1'b1;
    #1;
    chk("midrst_active", rx_active, 0);
    chk("midrst_byte",   rx_byte,   8'h00);
    chk("midrst_dv",     rx_dv,     0);
    chk("midrst_ferr",   frame_err, 0);
    last_good_byte = 8'h00;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(4 * CPB);
    chk("midrst_no_strobe", dv_cyc_q.size() + ferr_q.size(), 0);
    clear_mon();
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(12);
    check_batch("post_reset");

`ifdef UART_RX_PARITY_EN
    // Parity good then parity bad
    clear_mon();
    send_frame(8'h01, 1'b1, 1'b1);
    idle(CPB);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(12);
    check_batch("parity");
`endif

    // Randomized batches of frames with random gaps and framing errors
    for (int it = 0; it < 30; it++) begin
      int nf;
      clear_mon();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        b    = 8'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        par  = (^b) ^ ($urandom_range(0, 3) == 0);
        send_frame(b, stop, par);
        if (!stop) gap = $urandom_range(1, 3) * CPB + $urandom_range(0, 3);
        else       gap = $urandom_range(0, 2) * CPB + $urandom_range(0, 3);
        if (gap > 0) idle(gap);
      end
      idle(12);
      check_batch("random");
      chk("random_byte_reg", rx_byte, last_good_byte);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the existing 8N1 UART transmitter. It sits on the same clock domain and the same `CLKS_PER_BIT` setting as the transmitter. The asynchronous serial line is synchronised, each bit is sampled at mid-bit, and the block delivers one byte per frame with a single-cycle valid strobe. Framing errors are detected, and break (line stuck low) conditions are held off until the line returns high.

## Interface
- `CLKS_PER_BIT`, default 217 — clocks per bit (clock frequency / baud rate); minimum 4.
- `i_Clock`  in  1  — system clock; all logic on the rising edge.
- `i_Rst`  in  1  — reset, asynchronous, active-high.
- `i_RX_Serial`  in  1  — asynchronous serial line; idle high.
- `o_RX_DV`  out  1  — one-cycle strobe: `o_RX_Byte` holds a valid received byte.
- `o_RX_Byte`  out  8  — last received byte; held until the next `o_RX_DV`.
- `o_RX_Active`  out  1  — high from start-bit detection until the frame ends.
- `o_Frame_Err`  out  1  — one-cycle strobe: the stop bit was sampled low.
- `o_Parity_Err`  out  1  — one-cycle strobe: parity mismatch (see Configuration).

## Operation
- **Synchroniser:** two-flop synchroniser on `i_RX_Serial`, both flops reset to 1. All decisions use the second-stage output, called `rx_s` below.
- **Clock counter:** width `$clog2(CLKS_PER_BIT)+1`. Bit index: 3 bits. Shift register: 8 bits, LSB first.
- **IDLE:** counter and index cleared. `rx_s==0` → START.
- **START:**
  - Count to `(CLKS_PER_BIT-1)/2` (integer divide), then sample `rx_s`.
  - Sample 0 → clear counter, go to DATA.
  - Sample 1 → glitch: return to IDLE. No strobe is raised.
- **DATA:**
  - Count to `CLKS_PER_BIT-1`, then sample `rx_s` into bit `index`.
  - Index < 7 → increment index and stay in DATA.
  - Index = 7 → clear index, go to STOP (or PARITY when compiled in).
- **STOP:** count to `CLKS_PER_BIT-1`, then sample.
  - Sample 1 → load `o_RX_Byte` and pulse `o_RX_DV`.
  - Sample 0 → pulse `o_Frame_Err`. `o_RX_Byte` is not updated and `o_RX_DV` is not pulsed.
  - Either way, go to CLEANUP.
- **CLEANUP:**
  - After a good frame: one cycle, then IDLE.
  - After a framing error: hold in CLEANUP until `rx_s==1`, then IDLE. This is break hold-off.
- **`o_RX_Active`:** set on the IDLE→START transition. Cleared on START→IDLE (glitch) and on entry to CLEANUP.
- **Unused state encodings** → IDLE.

## Timing
- **Reset values:** `o_RX_DV=0`, `o_RX_Byte=8'h00`, `o_RX_Active=0`, `o_Frame_Err=0`, `o_Parity_Err=0`, state = IDLE, synchroniser = 1.
- **Reset mid-frame:** the partial frame is discarded with no strobe.
- **Latency:** a pin falling edge is seen by the FSM after 2 clocks.
- **Sample points:** each sample lands at mid-bit ±1 clock.
- **Strobes:**
  - `o_RX_DV`, `o_Frame_Err` and `o_Parity_Err` are registered.
  - They are high for exactly the one cycle after the stop-bit sample.
  - `o_RX_Byte` changes in the same cycle that `o_RX_DV` rises.
- **Back-to-back frames:** a start bit immediately following a stop bit must be received. CLEANUP plus detection must consume less than half a bit.
- **No handshake:** there is no backpressure. The consumer must take the byte within one frame time.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:**
  - A PARITY state sits between DATA and STOP, one bit long and sampled at mid-bit.
  - Even parity: the expected bit is the XOR of the 8 data bits.
  - On a mismatch, `o_Parity_Err` pulses in the same cycle as `o_RX_DV`. The byte is still delivered.
  - On a framing error, the parity result is discarded.
- **Undefined:** no PARITY state; `o_Parity_Err` is tied to 0.

## Test plan
All scenarios use `CLKS_PER_BIT=8`.
1. **Single byte:** send 0xA5, 8N1 → exactly one `o_RX_DV` pulse with `o_RX_Byte=0xA5`; `o_Frame_Err=0`; `o_RX_Active` low after the stop bit.
2. **Back-to-back:** send 0x00 then 0xFF with zero idle between frames → two `o_RX_DV` pulses carrying 0x00 then 0xFF, exactly 80 clocks apart.
3. **Start glitch:** drive `i_RX_Serial` low for 2 clocks on an idle line → no strobes; `o_RX_Active` pulses and returns to 0 within 6 clocks.
4. **Framing error and break:** send 0x3C with stop bit = 0, then hold the line low for 20 bit times → one `o_Frame_Err` pulse; no `o_RX_DV`; `o_RX_Byte` unchanged. No further events until the line goes high; a following 0x3C frame is received correctly.
5. **Reset mid-frame:** assert `i_Rst` during data bit 4 → all outputs go to reset values immediately with no strobe. After release, 0x5A is received correctly.
6. **Parity (`UART_RX_PARITY_EN`):**
   - Send 0x01 with parity 1 → `o_RX_DV` pulses, `o_RX_Byte=0x01`, `o_Parity_Err=0`.
   - Send 0x01 with parity 0 → `o_RX_DV` and `o_Parity_Err` pulse in the same cycle.
